// File: rtl/exec_unit_seq.sv
// Multi-cycle execution unit: a small register-file memory feeding an ALU
// through a fixed IDLE -> RD1 -> RD2 -> EXE -> WB sequence.
module exec_unit_seq #(
  parameter int WIDTH = 8,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    addr2,
  input  logic [AW-1:0]    addr3,
  input  logic [WIDTH-1:0] number,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out1,
  output logic [3:0]       flag1
);
  localparam int M = WIDTH - 1;

  typedef enum logic [2:0] {IDLE, RD1, RD2, EXE, WB} state_t;
  state_t r_state, w_next;

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [3:0]       r_op;
  logic [AW-1:0]    r_addr1, r_addr2, r_addr3;
  logic [WIDTH-1:0] r_num, r_a, r_b, r_out;
  logic [3:0]       r_flag;

  logic [AW-1:0]    w_rd_addr;
  logic [WIDTH-1:0] w_rd_data, w_opb, w_res;
  logic [WIDTH:0]   w_add, w_sub;
  logic             w_c, w_v, w_writes, w_wb_we, w_ld_we;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RD1;
      RD1:     w_next = RD2;
      RD2:     w_next = EXE;
      EXE:     w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Single read path shared by both operand fetch states.
  assign w_rd_addr = (r_state == RD1) ? r_addr1 : r_addr2;
  assign w_rd_data = r_mem[w_rd_addr];

  assign w_writes = (r_op <= 4'hB);
  assign w_wb_we  = !rst && (r_state == WB) && w_writes;
  assign w_ld_we  = !rst && (r_state == IDLE) && ld_en;

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wb_we)      r_mem[r_addr3] <= r_out;
    else if (w_ld_we) r_mem[ld_addr] <= ld_data;
  end

  assign w_opb = (r_op == 4'h8 || r_op == 4'h9) ? WIDTH'(1) : r_b;
  assign w_add = {1'b0, r_a} + {1'b0, w_opb};
  assign w_sub = {1'b0, r_a} - {1'b0, w_opb};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      4'h0, 4'h8: begin
        w_res = w_add[M:0];
        w_c   = w_add[WIDTH];
        w_v   = (r_a[M] == w_opb[M]) && (w_res[M] != r_a[M]);
      end
      4'h1, 4'h9, 4'hC: begin
        w_res = w_sub[M:0];
        w_c   = w_sub[WIDTH];
        w_v   = (r_a[M] != w_opb[M]) && (w_res[M] != r_a[M]);
      end
      4'h2: w_res = r_a & r_b;
      4'h3: w_res = r_a | r_b;
      4'h4: w_res = r_a ^ r_b;
      4'h5: w_res = ~r_a;
      4'h6: begin
        w_res = {r_a[M-1:0], 1'b0};
        w_c   = r_a[M];
      end
      4'h7: begin
        w_res = {1'b0, r_a[M:1]};
        w_c   = r_a[0];
      end
      4'hA: w_res = r_a;
      4'hB: w_res = r_num;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_addr3 <= '0;
      r_num   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_flag  <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_op    <= opcode;
          r_addr1 <= addr1;
          r_addr2 <= addr2;
          r_addr3 <= addr3;
          r_num   <= number;
        end
        RD1: r_a <= w_rd_data;
        RD2: r_b <= w_rd_data;
        EXE: begin
          // CMP updates flags only; D-F leave both result and flags alone.
          if (r_op <= 4'hC) r_flag <= {w_v, w_res[M], ~|w_res, w_c};
          if (w_writes)     r_out  <= w_res;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != IDLE);
  assign done  = (r_state == WB) && !rst;
  assign a     = r_a;
  assign b     = r_b;
  assign out1  = r_out;
  assign flag1 = r_flag;
endmodule
